// File: rtl/ps2_scancode_decoder_if.sv
// Byte-in / key-event-out bundle between the PS/2 receiver, the scan-code
// decoder and the game control FSM.
interface ps2_scancode_decoder_if;
    logic [7:0] received_data;
    logic       received_data_en;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_extended;
    logic       key_released;
    logic       cmd_hit;
    logic       cmd_stand;
    logic       cmd_deal;
    logic       cmd_confirm;
    logic [3:0] keys_held;
    logic       seq_error;

    modport master (
        output received_data, received_data_en,
        input  key_valid, key_code, key_extended, key_released,
        input  cmd_hit, cmd_stand, cmd_deal, cmd_confirm, keys_held, seq_error
    );

    modport slave (
        input  received_data, received_data_en,
        output key_valid, key_code, key_extended, key_released,
        output cmd_hit, cmd_stand, cmd_deal, cmd_confirm, keys_held, seq_error
    );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// Set-2 scan-code decoder: E0/F0 prefix tracking, key events, debounced game
// command pulses and a held-key bitmap, with a prefix timeout.
module ps2_scancode_decoder #(
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    ps2_scancode_decoder_if.slave  bus
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             key_valid_r;
    logic [7:0]       key_code_r;
    logic             key_extended_r;
    logic             key_released_r;
    logic [3:0]       cmd_r;
    logic [3:0]       keys_held_r;
    logic             seq_error_r;

    logic       is_e0_s;
    logic       is_f0_s;
    logic       ev_s;
    logic       ev_ext_s;
    logic       ev_brk_s;
    logic [3:0] game_s;

    // Controller chatter (BAT ok, ACK, resend, errors) that never forms an event.
    function automatic logic is_ignored(input logic [7:0] b);
        case (b)
            8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF: is_ignored = 1'b1;
            default:                           is_ignored = 1'b0;
        endcase
    endfunction

    // Bit position follows keys_held: {confirm, deal, stand, hit}.
    function automatic logic [3:0] game_mask(input logic [7:0] b);
        case (b)
            8'h33:   game_mask = 4'b0001;
            8'h1B:   game_mask = 4'b0010;
            8'h29:   game_mask = 4'b0100;
            8'h5A:   game_mask = 4'b1000;
            default: game_mask = 4'b0000;
        endcase
    endfunction

    // Classify the current strobe as a completed key event, if it is one.
    always_comb begin
        is_e0_s  = (bus.received_data == 8'hE0);
        is_f0_s  = (bus.received_data == 8'hF0);
        ev_s     = 1'b0;
        ev_ext_s = 1'b0;
        ev_brk_s = 1'b0;
        if (bus.received_data_en && !is_e0_s && !is_f0_s) begin
            case (state_r)
                IDLE:    ev_s = ~is_ignored(bus.received_data);
                EXT:     begin ev_s = 1'b1; ev_ext_s = 1'b1; end
                BRK:     begin ev_s = 1'b1; ev_brk_s = 1'b1; end
                EXT_BRK: begin ev_s = 1'b1; ev_ext_s = 1'b1; ev_brk_s = 1'b1; end
                default: ev_s = 1'b0;
            endcase
        end else begin
            ev_s = 1'b0;
        end
        game_s = (ev_s && !ev_ext_s) ? game_mask(bus.received_data) : 4'b0000;
    end

    // Prefix FSM, timeout counter and all registered outputs.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_r        <= IDLE;
            cnt_r          <= {CNT_W{1'b0}};
            key_valid_r    <= 1'b0;
            key_code_r     <= 8'h00;
            key_extended_r <= 1'b0;
            key_released_r <= 1'b0;
            cmd_r          <= 4'b0000;
            keys_held_r    <= 4'b0000;
            seq_error_r    <= 1'b0;
        end else begin
            key_valid_r <= 1'b0;
            cmd_r       <= 4'b0000;
            seq_error_r <= 1'b0;
            if (bus.received_data_en) begin
                cnt_r <= {CNT_W{1'b0}};
                case (state_r)
                    IDLE: begin
                        if (is_e0_s)      state_r <= EXT;
                        else if (is_f0_s) state_r <= BRK;
                        else              state_r <= IDLE;
                    end
                    EXT: begin
                        if (is_f0_s) begin
                            state_r <= EXT_BRK;
                        end else if (is_e0_s) begin
                            seq_error_r <= 1'b1;
                            state_r     <= EXT;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    BRK, EXT_BRK: begin
                        if (is_e0_s) begin
                            seq_error_r <= 1'b1;
                            state_r     <= EXT;
                        end else if (is_f0_s) begin
                            seq_error_r <= 1'b1;
                            state_r     <= BRK;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    default: state_r <= IDLE;
                endcase
                if (ev_s) begin
                    key_valid_r    <= 1'b1;
                    key_code_r     <= bus.received_data;
                    key_extended_r <= ev_ext_s;
                    key_released_r <= ev_brk_s;
                    if (ev_brk_s) begin
                        keys_held_r <= keys_held_r & ~game_s;
                    end else begin
                        keys_held_r <= keys_held_r | game_s;
                        // Typematic repeats of an already-held key stay silent.
                        cmd_r       <= game_s & ~keys_held_r;
                    end
                end
            end else if (state_r != IDLE) begin
                if (cnt_r == CNT_TERM) begin
                    state_r     <= IDLE;
                    seq_error_r <= 1'b1;
                    cnt_r       <= {CNT_W{1'b0}};
                end else begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end else begin
                cnt_r <= {CNT_W{1'b0}};
            end
        end
    end

    assign bus.key_valid    = key_valid_r;
    assign bus.key_code     = key_code_r;
    assign bus.key_extended = key_extended_r;
    assign bus.key_released = key_released_r;
    assign bus.cmd_hit      = cmd_r[0];
    assign bus.cmd_stand    = cmd_r[1];
    assign bus.cmd_deal     = cmd_r[2];
    assign bus.cmd_confirm  = cmd_r[3];
    assign bus.keys_held    = keys_held_r;
    assign bus.seq_error    = seq_error_r;
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Scoreboard bench for ps2_scancode_decoder: directed test-plan sequences
// followed by randomized byte streams, checked against a prefix-flag model.
module tb_ps2_scancode_decoder;
    localparam int T = 16;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;
    int   cyc      = 0;
    int   checks   = 0;
    int   errors   = 0;

    ps2_scancode_decoder_if bus ();

    ps2_scancode_decoder #(.TIMEOUT_CYCLES(T)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic       kv;
        logic [7:0] code;
        logic       ext;
        logic       rel;
        logic [3:0] cmd;
        logic [3:0] held;
        logic       err;
    } exp_t;

    exp_t q[$];

    // Reference model state: pending prefixes, last event, held keys.
    bit         pend_e, pend_f;
    int         idle_cnt;
    logic [3:0] m_held;
    logic [7:0] m_code;
    logic       m_ext, m_rel;

    function automatic logic [3:0] key_bit(input logic [7:0] b);
        if (b == 8'h33)      return 4'b0001;
        else if (b == 8'h1B) return 4'b0010;
        else if (b == 8'h29) return 4'b0100;
        else if (b == 8'h5A) return 4'b1000;
        else                 return 4'b0000;
    endfunction

    task automatic model_clear();
        pend_e = 0; pend_f = 0; idle_cnt = 0;
        m_held = 4'b0000; m_code = 8'h00; m_ext = 1'b0; m_rel = 1'b0;
    endtask

    task automatic push_event(input logic brk, input logic ext, input logic [7:0] code);
        exp_t e;
        logic [3:0] msk;
        logic [3:0] cmd;
        msk = ext ? 4'b0000 : key_bit(code);
        cmd = 4'b0000;
        if (brk) begin
            m_held = m_held & ~msk;
        end else begin
            if ((m_held & msk) == 4'b0000) cmd = msk;
            m_held = m_held | msk;
        end
        m_code = code; m_ext = ext; m_rel = brk;
        e = '{cyc + 1, 1'b1, code, ext, brk, cmd, m_held, 1'b0};
        q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e = '{cyc + 1, 1'b0, m_code, m_ext, m_rel, 4'b0000, m_held, 1'b1};
        q.push_back(e);
    endtask

    task automatic model(input logic en, input logic [7:0] b);
        if (!en) begin
            if (pend_e || pend_f) begin
                idle_cnt++;
                if (idle_cnt == T) begin
                    push_err();
                    pend_e = 0; pend_f = 0; idle_cnt = 0;
                end
            end
            return;
        end
        idle_cnt = 0;
        if (!pend_e && !pend_f) begin
            if (b == 8'hE0) pend_e = 1;
            else if (b == 8'hF0) pend_f = 1;
            else if (!(b inside {8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF})) push_event(1'b0, 1'b0, b);
        end else if (!pend_f) begin
            if (b == 8'hF0) pend_f = 1;
            else if (b == 8'hE0) push_err();
            else begin push_event(1'b0, 1'b1, b); pend_e = 0; end
        end else begin
            if (b == 8'hE0) begin push_err(); pend_e = 1; pend_f = 0; end
            else if (b == 8'hF0) begin push_err(); pend_e = 0; pend_f = 1; end
            else begin push_event(1'b1, pend_e, b); pend_e = 0; pend_f = 0; end
        end
    endtask

    task automatic step(input logic en, input logic [7:0] b);
        @(negedge CLOCK_50);
        bus.received_data_en = en;
        bus.received_data    = b;
        model(en, b);
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    task automatic check_reset_outputs();
        checks++;
        if (bus.key_valid !== 1'b0 || bus.key_code !== 8'h00 || bus.key_extended !== 1'b0 ||
            bus.key_released !== 1'b0 || bus.seq_error !== 1'b0 || bus.keys_held !== 4'b0000 ||
            {bus.cmd_confirm, bus.cmd_deal, bus.cmd_stand, bus.cmd_hit} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state: got kv=%b code=%h ext=%b rel=%b err=%b held=%b cmd=%b, required all zero",
                     bus.key_valid, bus.key_code, bus.key_extended, bus.key_released, bus.seq_error,
                     bus.keys_held, {bus.cmd_confirm, bus.cmd_deal, bus.cmd_stand, bus.cmd_hit});
        end
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_before_reset: got %0d queued, required 0", q.size());
            q.delete();
        end
        reset = 1'b1;
        bus.received_data_en = 1'b0;
        model_clear();
        @(negedge CLOCK_50);
        check_reset_outputs();
        @(negedge CLOCK_50);
        reset = 1'b0;
    endtask

    // Monitor: every output pulse is matched against the head of the queue.
    initial begin
        exp_t e;
        logic pulse;
        forever begin
            @(negedge CLOCK_50);
            if (!reset) begin
                pulse = bus.key_valid | bus.seq_error | bus.cmd_hit | bus.cmd_stand |
                        bus.cmd_deal | bus.cmd_confirm;
                if (pulse) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_pulse cyc=%0d: got kv=%b err=%b code=%h, required no pulse",
                                 cyc, bus.key_valid, bus.seq_error, bus.key_code);
                    end else begin
                        e = q.pop_front();
                        if (e.cyc != cyc || bus.key_valid !== e.kv || bus.seq_error !== e.err ||
                            bus.key_code !== e.code || bus.key_extended !== e.ext ||
                            bus.key_released !== e.rel || bus.keys_held !== e.held ||
                            {bus.cmd_confirm, bus.cmd_deal, bus.cmd_stand, bus.cmd_hit} !== e.cmd) begin
                            errors++;
                            $display("FAIL event cyc=%0d: got kv=%b err=%b code=%h ext=%b rel=%b cmd=%b held=%b, required cyc=%0d kv=%b err=%b code=%h ext=%b rel=%b cmd=%b held=%b",
                                     cyc, bus.key_valid, bus.seq_error, bus.key_code, bus.key_extended,
                                     bus.key_released,
                                     {bus.cmd_confirm, bus.cmd_deal, bus.cmd_stand, bus.cmd_hit},
                                     bus.keys_held, e.cyc, e.kv, e.err, e.code, e.ext, e.rel, e.cmd, e.held);
                        end
                    end
                end else if (q.size() != 0 && q[0].cyc <= cyc) begin
                    checks++;
                    errors++;
                    e = q.pop_front();
                    $display("FAIL missing_pulse cyc=%0d: got no pulse, required kv=%b err=%b code=%h",
                             cyc, e.kv, e.err, e.code);
                end
            end
        end
    end

    initial begin
        int r;
        int k;
        logic [7:0] b;
        bus.received_data_en = 1'b0;
        bus.received_data    = 8'h00;
        model_clear();
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        check_reset_outputs();
        reset = 1'b0;

        send(8'h33); idle(2);
        send(8'h33); send(8'h33); send(8'hF0); send(8'h33); idle(2);
        send(8'hE0); send(8'h5A); send(8'hE0); send(8'hF0); send(8'h5A); idle(2);
        send(8'hAA); send(8'hFA); send(8'h1B); idle(2);
        send(8'hF0); idle(T + 2);
        send(8'h29); send(8'hF0); send(8'h29); send(8'hF0); send(8'h1B); idle(2);
        // Strobe arriving on the terminal-count cycle still wins.
        send(8'hE0); idle(T - 1); send(8'h5A); idle(2);
        send(8'hE0); send(8'hE0); send(8'hF0); send(8'hF0); send(8'hE0); send(8'h33); idle(2);
        send(8'h5A); send(8'h33);
        send(8'hE0);
        do_reset();
        send(8'h29); idle(2);

        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                do_reset();
            end else if (r < 6) begin
                idle($urandom_range(10, 20));
            end else begin
                k = $urandom_range(0, 9);
                case (k)
                    0: b = 8'hE0;
                    1: b = 8'hF0;
                    2: b = 8'h33;
                    3: b = 8'h1B;
                    4: b = 8'h29;
                    5: b = 8'h5A;
                    6: b = 8'hAA;
                    7: b = 8'hFA;
                    8: b = 8'hFE;
                    default: b = 8'($urandom);
                endcase
                step($urandom_range(0, 3) != 0, b);
            end
        end

        idle(3);
        @(negedge CLOCK_50);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d expected events still queued, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ps2_scancode_decoder.md
# ps2_scancode_decoder

Downstream consumer of the PS/2 controller's receive path. It turns the raw Set-2 scan-code byte stream into key events: make/break, extended prefix, and code. It also emits debounced one-cycle game command pulses (hit, stand, deal, confirm) for the blackjack control FSM, plus a held-key bitmap.

## Interface
- TIMEOUT_CYCLES, 2_500_000: cycles (50 ms at 50 MHz) allowed between a prefix byte and its follow-up byte before the sequence is abandoned.
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- received_data  in  8  byte from PS/2 controller; valid only while received_data_en = 1.
- received_data_en  in  1  one-cycle strobe marking a new received byte.
- key_valid  out  1  one-cycle pulse: a complete key event was decoded.
- key_code  out  8  final (non-prefix) byte of the last event; held until next event.
- key_extended  out  1  last event carried the E0 prefix; held.
- key_released  out  1  last event was a break (F0 prefix); held.
- cmd_hit, cmd_stand, cmd_deal, cmd_confirm  out  1 each  one-cycle pulses on fresh non-extended makes of 0x33 (H), 0x1B (S), 0x29 (Space), 0x5A (Enter).
- keys_held  out  4  {confirm, deal, stand, hit} currently pressed.
- seq_error  out  1  one-cycle pulse: malformed sequence or prefix timeout.

## Operation
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen). The FSM acts only on cycles where received_data_en = 1, except for the timeout.
- IDLE:
  - E0 -> EXT; F0 -> BRK.
  - 0xAA, 0xFA, 0xFE, 0x00, 0xFF are ignored: no event, stay IDLE.
  - Any other byte -> make event, extended = 0.
- EXT:
  - F0 -> EXT_BRK.
  - E0 -> seq_error, stay EXT.
  - Other -> make event, extended = 1, -> IDLE.
- BRK and EXT_BRK:
  - E0 -> seq_error, -> EXT.
  - F0 -> seq_error, -> BRK.
  - Other -> break event, extended = 0 (BRK) or 1 (EXT_BRK), -> IDLE.
- Event: key_valid = 1, and key_code, key_extended, key_released are loaded in the same cycle.
- Game keys apply only when extended = 0 and the code matches one of the four commands.
  - Make with held bit clear -> set held bit, pulse the matching cmd_*.
  - Make with held bit set (typematic repeat) -> key_valid still pulses, no cmd_* pulse.
  - Break -> clear held bit, no cmd_* pulse. A break for a key not held is harmless.
- Extended codes (e.g. E0 5A) never touch keys_held or cmd_*.
- Timeout counter:
  - Cleared on every received_data_en.
  - Increments each cycle while the FSM is not IDLE.
  - When it reaches TIMEOUT_CYCLES-1 with no strobe: -> IDLE, seq_error pulse, no event.
  - Counter width is ceil(log2(TIMEOUT_CYCLES)); it never wraps.

## Timing
- Reset values: FSM IDLE, counter 0, keys_held 4'b0000, key_code 8'h00, key_extended 0, key_released 0, all pulses 0.
- Latency: key_valid, cmd_*, seq_error assert exactly 1 cycle after the received_data_en cycle carrying the final byte. Each is high for one cycle.
- keys_held updates in the same cycle as key_valid.
- Back-to-back strobes on consecutive cycles are each processed; no throughput limit.
- A strobe in the same cycle the counter hits terminal count: the strobe wins, no timeout, byte is decoded normally.
- Reset asserted mid-sequence: immediate return to IDLE, held bits lost, no pulse generated on release of reset.
- Outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Byte 0x33 strobed from IDLE -> next cycle key_valid = 1, cmd_hit = 1, key_code = 0x33, key_extended = 0, key_released = 0, keys_held = 4'b0001.
- Bytes 0x33, 0x33, 0x33 (repeat), then F0, 33 -> cmd_hit pulses once only; key_valid pulses 4 times; final event has key_released = 1; keys_held = 0.
- Bytes E0, 5A then E0, F0, 5A -> two events with key_extended = 1 and key_code 0x5A; cmd_confirm never pulses; keys_held stays 0.
- Bytes 0xAA and 0xFA from IDLE -> no key_valid, no seq_error; then 0x1B -> cmd_stand.
- Byte F0 then silence for TIMEOUT_CYCLES (use 16 in bench) -> seq_error pulse, FSM IDLE; then 0x29 -> make event, cmd_deal, key_released = 0.
- Bytes E0, 29 with reset pulsed between them -> no event; keys_held = 0; subsequent 0x29 -> cmd_deal, key_extended = 0.
